// File: rtl/iq_window_ctrl_if.sv
// Handshake and status bundle between the I/Q window sequencer
// and its environment (sample source, correlator, phase tracker).
interface iq_window_ctrl_if;
   logic       sample_valid;
   logic       start;
   logic       stop;
   logic       corr_ready;
   logic       phase_adj_valid;
   logic [1:0] phase_adj;
   logic       shift_en;
   logic [4:0] fill_cnt;
   logic       win_valid;
   logic       overrun;
   logic [1:0] state;

   modport master (
      output sample_valid, start, stop, corr_ready,
      output phase_adj_valid, phase_adj,
      input  shift_en, fill_cnt, win_valid, overrun, state
   );

   modport slave (
      input  sample_valid, start, stop, corr_ready,
      input  phase_adj_valid, phase_adj,
      output shift_en, fill_cnt, win_valid, overrun, state
   );
endinterface

// File: rtl/iq_window_ctrl.sv
// Sample-phase sequencer: one window shift every OSR samples,
// fill tracking, correlator handshake and overrun detection.
module iq_window_ctrl #(
   parameter int OSR   = 5,
   parameter int DEPTH = 20
) (
   input logic            clk,
   input logic            reset,
   iq_window_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FILL = 2'b01,
      RUN  = 2'b10
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] phase_q, phase_d;
   logic [4:0] fill_q, fill_d;
   logic       shift_q, shift_d;
   logic       win_q, win_d;
   logic       ovr_q, ovr_d;
   logic       pend_q, pend_d;
   logic       pend_adv_q, pend_adv_d;

   logic       req_ok, eff_req, eff_adv;
   logic       wrap, full, rise;
   logic [4:0] inc, sum;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      fill_d     = fill_q;
      shift_d    = 1'b0;
      win_d      = win_q;
      ovr_d      = ovr_q;
      pend_d     = pend_q;
      pend_adv_d = pend_adv_q;

      req_ok  = (state_q == RUN) && bus.phase_adj_valid &&
                (bus.phase_adj == 2'b01 || bus.phase_adj == 2'b10);
      eff_req = pend_q || req_ok;
      eff_adv = pend_q ? pend_adv_q : (bus.phase_adj == 2'b01);
      inc     = eff_req ? (eff_adv ? 5'd2 : 5'd0) : 5'd1;
      sum     = {1'b0, phase_q} + inc;
      wrap    = sum >= 5'(OSR);
      full    = (state_q == FILL) && (fill_q == 5'(DEPTH - 1));
      rise    = shift_q && ((state_q == RUN) || full);

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = FILL;
               ovr_d   = 1'b0;
            end
         end
         FILL, RUN: begin
            if (bus.sample_valid) begin
               phase_d = wrap ? 4'(sum - 5'(OSR)) : sum[3:0];
               shift_d = wrap;
               pend_d  = 1'b0;
            end else if (!pend_q && req_ok) begin
               pend_d     = 1'b1;
               pend_adv_d = (bus.phase_adj == 2'b01);
            end
            if (shift_q && state_q == FILL) begin
               fill_d = fill_q + 5'd1;
               if (full) state_d = RUN;
            end
            // a fresh window landing on an unaccepted one is an overrun
            if (rise) begin
               win_d = 1'b1;
               if (win_q && !bus.corr_ready) ovr_d = 1'b1;
            end else if (win_q && bus.corr_ready) begin
               win_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.stop) begin
         state_d    = IDLE;
         phase_d    = 4'd0;
         fill_d     = 5'd0;
         shift_d    = 1'b0;
         win_d      = 1'b0;
         pend_d     = 1'b0;
         pend_adv_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         phase_q    <= 4'd0;
         fill_q     <= 5'd0;
         shift_q    <= 1'b0;
         win_q      <= 1'b0;
         ovr_q      <= 1'b0;
         pend_q     <= 1'b0;
         pend_adv_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         fill_q     <= fill_d;
         shift_q    <= shift_d;
         win_q      <= win_d;
         ovr_q      <= ovr_d;
         pend_q     <= pend_d;
         pend_adv_q <= pend_adv_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.fill_cnt  = fill_q;
   assign bus.shift_en  = shift_q;
   assign bus.win_valid = win_q;
   assign bus.overrun   = ovr_q;
endmodule
